// File: rtl/bnn_uart_pkg.sv
// Shared definitions for the BNN UART link.
//   uart_state_e   : frame FSM states, common to the RX and TX paths
//   UART_IDLE_LVL  : line level of an idle UART wire (mark)
//   uart_params_ok : elaboration-time legality check of the link parameters
package bnn_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;

  function automatic bit uart_params_ok(input int unsigned cpb, input int unsigned data_bits,
                                        input int unsigned depth, input int unsigned margin);
    return (cpb >= 4) && ((cpb % 2) == 0) && (data_bits >= 5) && (data_bits <= 9) &&
           (depth >= 4) && ((depth & (depth - 1)) == 0) && (margin < depth);
  endfunction

endpackage

// File: rtl/bnn_sync_fifo.sv
// Show-ahead synchronous FIFO used as the UART RX buffer.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers)
//   push       : write push_data; ignored when full unless a pop happens in the same cycle
//   pop        : drop the head entry; ignored when empty
//   pop_data   : current head entry, zero while empty
//   full/empty : occupancy flags
//   free_cnt   : number of free entries
module bnn_sync_fifo
  import bnn_uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign free_cnt = DEPTH_W - (wr_ptr_q - rd_ptr_q);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pop is taken first, so a push into a full FIFO succeeds when a pop happens alongside.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bnn_uart_link.sv
// Full-duplex UART link between the host pins and the BNN core byte streams.
// Frames are LSB first, DATA_BITS payload, no parity, one stop bit.
//   clk, rst_n          : system clock, asynchronous active-low reset (synchronous release)
//   uart_rx, uart_rts_n : host serial input and host ready-to-receive (both synchronised)
//   uart_tx, uart_cts_n : serial output and clear-to-send towards the host
//   rx_data/valid/ready : show-ahead RX FIFO head towards the core
//   tx_data/valid/ready : byte handshake from the core into the transmitter
//   frame_err           : one-cycle pulse on a bad stop bit
//   rx_overrun          : sticky, byte arrived while the RX FIFO was full
module bnn_uart_link
  import bnn_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CTS_MARGIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  input  logic                 uart_rts_n,
  output logic                 uart_tx,
  output logic                 uart_cts_n,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 frame_err,
  output logic                 rx_overrun
);

  if (!uart_params_ok(CLKS_PER_BIT, DATA_BITS, FIFO_DEPTH, CTS_MARGIN)) begin : g_param_check
    $error("bnn_uart_link: illegal parameter set");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  // TX stop bit leaves one cycle early: its final cycle is spent in IDLE so a
  // back-to-back handshake starts the next frame with no gap.
  localparam logic [CW-1:0] STOP_END  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [FW-1:0] CTS_LIM   = FW'(CTS_MARGIN);

  // Reset: asserted asynchronously, released through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [1:0] rx_sync_q, rts_sync_q;
  logic       rx_s, rts_s;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_sync_q  <= {2{UART_IDLE_LVL}};
      rts_sync_q <= 2'b11;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx};
      rts_sync_q <= {rts_sync_q[0], uart_rts_n};
    end
  end
  assign rx_s  = rx_sync_q[1];
  assign rts_s = rts_sync_q[1];

  // ---------------- RX ----------------
  uart_state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bits_q, rx_bits_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_err_wait_q, rx_err_wait_d;
  logic                 rx_push_q, rx_push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_overrun_q, cts_n_q;
  logic                 fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_free;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bits_d     = rx_bits_q;
    rx_shift_d    = rx_shift_q;
    rx_err_wait_d = rx_err_wait_q;
    rx_push_d     = 1'b0;
    frame_err_d   = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (!rx_s) begin
          rx_state_d = START;
          rx_cnt_d   = '0;
        end
      end
      START: begin
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d   = '0;
          rx_bits_d  = '0;
          // A start bit that is gone by mid-bit is a glitch, not a frame.
          rx_state_d = rx_s ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (rx_cnt_q == LAST_BIT) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bits_d  = rx_bits_q + BW'(1);
          if (rx_bits_q == LAST_DATA) rx_state_d = STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (rx_err_wait_q) begin
          // Bad stop bit: hold off until the line returns to idle.
          if (rx_s) begin
            rx_err_wait_d = 1'b0;
            rx_state_d    = IDLE;
          end
        end else if (rx_cnt_q == LAST_BIT) begin
          if (rx_s) begin
            rx_push_d  = 1'b1;
            rx_state_d = IDLE;
          end else begin
            frame_err_d   = 1'b1;
            rx_err_wait_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_state_q    <= IDLE;
      rx_cnt_q      <= '0;
      rx_bits_q     <= '0;
      rx_shift_q    <= '0;
      rx_err_wait_q <= 1'b0;
      rx_push_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      cts_n_q       <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bits_q     <= rx_bits_d;
      rx_shift_q    <= rx_shift_d;
      rx_err_wait_q <= rx_err_wait_d;
      rx_push_q     <= rx_push_d;
      frame_err_q   <= frame_err_d;
      // A pop in the same cycle makes room, so only a push against a full, unpopped FIFO overruns.
      rx_overrun_q  <= rx_overrun_q | (rx_push_q & fifo_full & ~rx_ready);
      cts_n_q       <= (fifo_free <= CTS_LIM);
    end
  end

  bnn_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .push      (rx_push_q),
    .push_data (rx_shift_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free_cnt  (fifo_free)
  );

  assign rx_valid   = ~fifo_empty;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
  assign uart_cts_n = cts_n_q;

  // ---------------- TX ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bits_q, tx_bits_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_ready   = (tx_state_q == IDLE) && !rts_s;
    case (tx_state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_state_d = START;
          tx_cnt_d   = '0;
          tx_shift_d = tx_data;
          tx_line_d  = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == LAST_BIT) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bits_d  = '0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tx_cnt_q == LAST_BIT) begin
          tx_cnt_d = '0;
          if (tx_bits_q == LAST_DATA) begin
            tx_state_d = STOP;
            tx_line_d  = UART_IDLE_LVL;
          end else begin
            tx_bits_d  = tx_bits_q + BW'(1);
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tx_cnt_q == STOP_END) tx_state_d = IDLE;
        else                      tx_cnt_d   = tx_cnt_q + CW'(1);
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= UART_IDLE_LVL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;

endmodule

// File: tb/tb_bnn_uart_link.sv
// Self-checking bench for bnn_uart_link (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=8, CTS_MARGIN=2).
module tb_bnn_uart_link;

  localparam int CPB    = 16;
  localparam int DB     = 8;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx, uart_rts_n, uart_tx, uart_cts_n;
  logic [DB-1:0] rx_data, tx_data;
  logic          rx_valid, rx_ready, tx_valid, tx_ready, frame_err, rx_overrun;

  always #5 clk = ~clk;

  bnn_uart_link #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH),
    .CTS_MARGIN   (MARGIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .uart_rts_n (uart_rts_n),
    .uart_tx    (uart_tx),
    .uart_cts_n (uart_cts_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_err  (frame_err),
    .rx_overrun (rx_overrun)
  );

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;

  // Reference model of the RX side: byte queue plus sticky overrun flag.
  logic [DB-1:0] model_q[$];
  logic          model_ovr = 1'b0;

  // Each registered frame_err pulse spans exactly one falling edge.
  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [DB-1:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= DB) return b[j-1];
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    for (int j = 0; j < DB + 1; j++) begin
      uart_rx = frame_bit(b, j);
      repeat (CPB) tick();
    end
    uart_rx = stop;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic model_push(input logic [DB-1:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    logic [DB-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    chk({tag, "_valid"}, rx_valid, model_q.size() > 0);
    chk({tag, "_data"}, rx_data, head);
    chk({tag, "_cts"}, uart_cts_n, (DEPTH - model_q.size()) <= MARGIN);
    chk({tag, "_ovr"}, rx_overrun, model_ovr);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_pop_valid"}, rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(model_q.pop_front());
    tick();
    check_rx(tag);
  endtask

  task automatic wait_tx_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, tx_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx"}, uart_tx, 1'b1);
    chk({tag, "_cts"}, uart_cts_n, 1'b0);
    chk({tag, "_rxv"}, rx_valid, 1'b0);
    chk({tag, "_rxd"}, rx_data, '0);
    chk({tag, "_txr"}, tx_ready, 1'b0);
    chk({tag, "_fe"}, frame_err, 1'b0);
    chk({tag, "_ovr"}, rx_overrun, 1'b0);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          exp_cts_n;
    logic          exp_ovr;
    int            exp_fe;
  } rx_vec_t;

  rx_vec_t vecs[10];

  initial begin
    int hs_at, ready_seen, nrand;
    logic [DB-1:0] b;
    logic [DB-1:0] pair[2];
    logic          st;

    // Fill to 8, overflow with 0x3C, then a bad-stop frame.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{8'h33, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h44, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h66, 1'b1, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h77, 1'b1, 1'b1, 1'b0, 0};
    vecs[8] = '{8'h3C, 1'b1, 1'b1, 1'b1, 0};
    vecs[9] = '{8'h55, 1'b0, 1'b1, 1'b1, 1};

    rst_n = 1'b0; uart_rx = 1'b1; uart_rts_n = 1'b1;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) tick();
    check_rx("post_reset");

    // RX table.
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) model_push(vecs[i].data);
      chk($sformatf("vec%0d_cts", i), uart_cts_n, vecs[i].exp_cts_n);
      chk($sformatf("vec%0d_ovr", i), rx_overrun, vecs[i].exp_ovr);
      chk($sformatf("vec%0d_fe", i), fe_cnt, vecs[i].exp_fe);
      check_rx($sformatf("vec%0d", i));
    end
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("drain%0d", i));
    chk("drain_empty", rx_valid, 1'b0);

    // Short start-bit glitch: no frame, no error, receiver still usable.
    uart_rx = 1'b0;
    repeat (5) tick();
    uart_rx = 1'b1;
    repeat (2 * CPB) tick();
    chk("glitch_fe", fe_cnt, 1);
    chk("glitch_valid", rx_valid, 1'b0);
    send_frame(8'h96, 1'b1);
    model_push(8'h96);
    check_rx("after_glitch");
    pop_one("after_glitch");

    // Randomised RX frames with occasional bad stop bits and random pops.
    nrand = 24;
    for (int i = 0; i < nrand; i++) begin
      b  = DB'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(b, st);
      if (st) model_push(b);
      check_rx($sformatf("rand%0d", i));
      for (int k = $urandom_range(0, 2); k > 0; k--)
        if (model_q.size() > 0) pop_one($sformatf("rand%0d", i));
    end
    while (model_q.size() > 0) pop_one("rand_drain");

    // Back-to-back TX of 0x81 and 0x7E.
    uart_rts_n = 1'b0;
    pair[0] = 8'h81;
    pair[1] = 8'h7E;
    tx_data = pair[0];
    tx_valid = 1'b1;
    wait_tx_ready("tx_ready_rts_low");
    tick();
    tx_data = pair[1];
    hs_at = -1;
    for (int i = 0; i < 2 * (DB + 2) * CPB; i++) begin
      chk($sformatf("b2b_bit%0d", i / CPB), uart_tx,
          frame_bit(pair[i / ((DB + 2) * CPB)], (i % ((DB + 2) * CPB)) / CPB));
      if (tx_valid && tx_ready && hs_at < 0) hs_at = i;
      tick();
      if (hs_at >= 0) tx_valid = 1'b0;
    end
    chk("b2b_handshake_cycle", hs_at, (DB + 2) * CPB - 1);
    chk("b2b_idle_line", uart_tx, 1'b1);

    // RTS withdrawn mid-frame: frame completes, then no further acceptance.
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    wait_tx_ready("tx_ready_c3");
    tick();
    tx_data = 8'h5A;
    for (int i = 0; i < (DB + 2) * CPB; i++) begin
      if (i == 80) uart_rts_n = 1'b1;
      chk($sformatf("rts_bit%0d", i / CPB), uart_tx, frame_bit(8'hC3, i / CPB));
      tick();
    end
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_ready) ready_seen++;
      tick();
    end
    chk("rts_blocked_ready", ready_seen, 0);
    chk("rts_blocked_line", uart_tx, 1'b1);

    // Leave a byte in the FIFO and a frame in flight each way, then reset.
    send_frame(8'h42, 1'b1);
    model_push(8'h42);
    check_rx("pre_reset");
    uart_rts_n = 1'b0;
    wait_tx_ready("tx_ready_5a");
    tick();
    tx_valid = 1'b0;
    uart_rx = 1'b0;
    repeat (50) tick();
    chk("pre_reset_tx", uart_tx, frame_bit(8'h5A, 50 / CPB));
    #2;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    model_q.delete();
    model_ovr = 1'b0;
    repeat (2 * CPB) tick();
    check_rx("after_reset");
    send_frame(8'hE7, 1'b1);
    model_push(8'hE7);
    check_rx("recovered");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
